mips32_prog_loader: RTL and testbench
=====================================

MIPS32_PROG_LOADER -- requirements
Module: mips32_prog_loader

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, meaning the instruction-memory word-address width.
REQ-002 SHALL have parameter MEM_DEPTH, default 1024, meaning the number of instruction-memory words.
REQ-003 SHALL have port clk1  input  1  sole clock; all state updates on posedge clk1.
REQ-004 SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 SHALL have port start  input  1  single-cycle request to begin a load.
REQ-006 SHALL have port load_base  input  ADDR_W  first word address, sampled on start.
REQ-007 SHALL have port load_count  input  ADDR_W+1  number of words to load, sampled on start.
REQ-008 SHALL have port in_valid  input  1  byte-stream valid.
REQ-009 SHALL have port in_byte  input  8  byte-stream data.
REQ-010 SHALL have port in_ready  output  1  byte-stream ready.
REQ-011 SHALL have port mem_we  output  1  instruction-memory write strobe.
REQ-012 SHALL have port mem_addr  output  ADDR_W  instruction-memory word address.
REQ-013 SHALL have port mem_wdata  output  32  assembled instruction word.
REQ-014 SHALL have port core_hold  output  1  holds the pipeline (gates HALTED/PC start) while high.
REQ-015 SHALL have port busy  output  1  load in progress.
REQ-016 SHALL have port done  output  1  load completed; level signal.
REQ-017 SHALL have port err  output  1  load rejected; level signal.
REQ-018 SHALL have port checksum  output  32  modulo-2^32 sum of all words written in the current load.

Function
REQ-019 SHALL implement the FSM states IDLE, RECV, WRITE, DONE and ERR.
REQ-020 SHALL move on start from IDLE, DONE or ERR to ERR when load_count==0 or load_base+load_count>MEM_DEPTH, and to RECV otherwise.
REQ-021 SHALL, on entering RECV from start, clear checksum, the byte counter, done and err.
REQ-022 SHALL ignore start while in RECV or WRITE.
REQ-023 SHALL drive in_ready=1 only in RECV; a byte transfers when in_valid&&in_ready.
REQ-024 SHALL assemble bytes big-endian, placing the first byte of a word in [31:24] and the fourth in [7:0].
REQ-025 SHALL move from RECV to WRITE on the fourth byte transfer.
REQ-026 SHALL, in WRITE, drive mem_we=1 for exactly one cycle, with mem_addr equal to the current address and mem_wdata equal to the assembled word; this is the cycle after the fourth byte is accepted.
REQ-027 SHALL, on leaving WRITE, increment the address, decrement the remaining count, and add the word to checksum.
REQ-028 SHALL go from WRITE to DONE when the remaining count reaches 0, and back to RECV otherwise.
REQ-029 SHALL never wrap the address, because the range is checked at start.
REQ-030 SHALL accept no bytes during WRITE, since in_ready=0 there.
REQ-031 SHALL keep mem_we=0 in all states other than WRITE.
REQ-032 SHALL drive busy=1 exactly in RECV and WRITE.
REQ-033 SHALL hold done=1 in DONE and err=1 in ERR.
REQ-034 SHALL drive core_hold=0 only in DONE, and 1 in all other states.
REQ-035 SHALL retain checksum until the next accepted start.

Reset
REQ-036 SHALL, on rst, enter IDLE and set core_hold=1, in_ready=0, mem_we=0, busy=0, done=0, err=0, checksum=0, and clear the address, count and byte counter.
REQ-037 SHALL, on rst mid-load, discard any partial word and perform no write in that cycle or afterwards.
REQ-038 SHALL give rst priority over start and over any byte transfer in the same cycle.

Structure
REQ-039 SHALL place the FSM state encoding and the MEM_DEPTH default in the shared mips32 package, alongside the opcode and type constants.
REQ-040 SHALL use one sub-module, mips32_byte_packer, containing the byte counter, the shift register and a word_valid pulse.

Verification
REQ-041 SHALL cover: start base=0 count=2 with bytes 28 01 00 0A 28 02 00 14 -> Mem[0]=32'h2801000A and Mem[1]=32'h28020014, checksum=32'h5003001E, done=1 and core_hold=0.
REQ-042 SHALL cover: start base=1020 count=5 -> err=1, no mem_we, in_ready=0.
REQ-043 SHALL cover: start count=0 -> err=1; a following valid start base=0 count=1 -> err clears and done=1 after 4 bytes.
REQ-044 SHALL cover: in_valid toggling every other cycle over 1 word -> a correct word, mem_we high exactly 1 cycle, 1 cycle after the 4th byte.
REQ-045 SHALL cover: rst asserted after 2 bytes of word 0 -> IDLE, no write, core_hold=1; a restart loads the correct data.
REQ-046 SHALL cover: start pulsed during RECV with a different base -> ignored; the original addresses are written.

Source files
------------

// File: rtl/mips32_prog_loader_pkg.sv
// Shared mips32 constants: loader FSM encoding, memory depth default and
// the instruction opcode/type constants used by the pipeline.
package mips32_prog_loader_pkg;

    localparam int MEM_DEPTH_DEF = 1024;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_RECV  = 3'd1;
    localparam logic [2:0] ST_WRITE = 3'd2;
    localparam logic [2:0] ST_DONE  = 3'd3;
    localparam logic [2:0] ST_ERR   = 3'd4;

    localparam logic [5:0] OP_ADD  = 6'h00;
    localparam logic [5:0] OP_SUB  = 6'h01;
    localparam logic [5:0] OP_LW   = 6'h08;
    localparam logic [5:0] OP_SW   = 6'h09;
    localparam logic [5:0] OP_ADDI = 6'h0A;
    localparam logic [5:0] OP_BEQZ = 6'h0E;
    localparam logic [5:0] OP_HLT  = 6'h3F;

    localparam logic [2:0] TY_RR_ALU = 3'd0;
    localparam logic [2:0] TY_RM_ALU = 3'd1;
    localparam logic [2:0] TY_LOAD   = 3'd2;
    localparam logic [2:0] TY_STORE  = 3'd3;
    localparam logic [2:0] TY_BRANCH = 3'd4;
    localparam logic [2:0] TY_HALT   = 3'd5;

    function automatic logic [5:0] get_opcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/mips32_prog_loader_if.sv
// Byte-stream input and instruction-memory write port of the program loader.
// A byte moves on a rising clk1 edge where in_valid && in_ready; the source may
// change in_byte only after such an edge, and mem_we is a single-cycle strobe.
interface mips32_prog_loader_if #(
    parameter int ADDR_W = 10
) ();
    logic              in_valid;
    logic [7:0]        in_byte;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;

    modport master (
        output in_valid, in_byte,
        input  in_ready, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  in_valid, in_byte,
        output in_ready, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/mips32_prog_loader_byte_packer.sv
// Shifts incoming bytes into a big-endian 32-bit word; word_valid_o flags the
// cycle in which the fourth byte of a word is being accepted.
module mips32_byte_packer (
    input  logic        clk1,
    input  logic        rst,
    input  logic        clr_i,
    input  logic        byte_en_i,
    input  logic [7:0]  byte_i,
    output logic [31:0] word_o,
    output logic        word_valid_o
);
    logic [1:0]  cnt_q;
    logic [31:0] word_q;

    assign word_o       = word_q;
    assign word_valid_o = byte_en_i && (cnt_q == 2'd3);

    always_ff @(posedge clk1) begin
        if (rst || clr_i) begin
            cnt_q  <= 2'd0;
            word_q <= 32'd0;
        end else if (byte_en_i) begin
            cnt_q  <= cnt_q + 2'd1;
            word_q <= {word_q[23:0], byte_i};
        end
    end
endmodule

// File: rtl/mips32_prog_loader.sv
// Loads a range of instruction memory from a byte stream, holding the core
// until the whole range is written and keeping a running checksum.
module mips32_prog_loader
    import mips32_prog_loader_pkg::*;
#(
    parameter int ADDR_W    = 10,
    parameter int MEM_DEPTH = MEM_DEPTH_DEF
) (
    input  logic                clk1,
    input  logic                rst,
    input  logic                start,
    input  logic [ADDR_W-1:0]   load_base,
    input  logic [ADDR_W:0]     load_count,
    mips32_prog_loader_if.slave bus,
    output logic                core_hold,
    output logic                busy,
    output logic                done,
    output logic                err,
    output logic [31:0]         checksum,
    output logic [2:0]          dbg_state
);
    localparam logic [ADDR_W+1:0] DEPTH_L = (ADDR_W+2)'(MEM_DEPTH);

    logic [2:0]        state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0]   remain_q, remain_d;
    logic [31:0]       chk_q, chk_d;
    logic              clr;
    logic              byte_en;
    logic              word_valid;
    logic [31:0]       word;
    logic [ADDR_W+1:0] end_sum;
    logic              range_bad;

    mips32_byte_packer u_packer (
        .clk1         (clk1),
        .rst          (rst),
        .clr_i        (clr),
        .byte_en_i    (byte_en),
        .byte_i       (bus.in_byte),
        .word_o       (word),
        .word_valid_o (word_valid)
    );

    // One bit of headroom so base+count past the end cannot alias back into range.
    assign end_sum   = {2'b00, load_base} + {1'b0, load_count};
    assign range_bad = (load_count == '0) || (end_sum > DEPTH_L);
    assign byte_en   = bus.in_valid && bus.in_ready;

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        remain_d = remain_q;
        chk_d    = chk_q;
        clr      = 1'b0;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    if (range_bad) begin
                        state_d = ST_ERR;
                    end else begin
                        state_d  = ST_RECV;
                        addr_d   = load_base;
                        remain_d = load_count;
                        chk_d    = 32'd0;
                        clr      = 1'b1;
                    end
                end
            end
            ST_RECV: begin
                if (word_valid) state_d = ST_WRITE;
            end
            ST_WRITE: begin
                chk_d    = chk_q + word;
                remain_d = remain_q - 1'b1;
                // The address only advances when another word follows, so it never wraps.
                if (remain_q == (ADDR_W+1)'(1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RECV;
                    addr_d  = addr_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk1) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            addr_q   <= '0;
            remain_q <= '0;
            chk_q    <= 32'd0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            remain_q <= remain_d;
            chk_q    <= chk_d;
        end
    end

    assign bus.in_ready  = (state_q == ST_RECV);
    assign bus.mem_we    = (state_q == ST_WRITE);
    assign bus.mem_addr  = addr_q;
    assign bus.mem_wdata = word;
    assign busy          = (state_q == ST_RECV) || (state_q == ST_WRITE);
    assign done          = (state_q == ST_DONE);
    assign err           = (state_q == ST_ERR);
    assign core_hold     = (state_q != ST_DONE);
    assign checksum      = chk_q;
    assign dbg_state     = state_q;
endmodule

// File: tb/tb_mips32_prog_loader.sv
// Bench for mips32_prog_loader: random byte streams against a word-level model
// of the load, with a scoreboard of the expected memory writes.
module tb_mips32_prog_loader;
    import mips32_prog_loader_pkg::*;

    localparam int AW    = 10;
    localparam int DEPTH = 1024;

    typedef logic [7:0] bytes_t[$];

    logic          clk1 = 1'b0;
    logic          rst;
    logic          start;
    logic [AW-1:0] load_base;
    logic [AW:0]   load_count;
    logic          core_hold, busy, done, err;
    logic [31:0]   checksum;
    logic [2:0]    dbg_state;

    mips32_prog_loader_if #(.ADDR_W(AW)) bus ();

    mips32_prog_loader #(.ADDR_W(AW), .MEM_DEPTH(DEPTH)) dut (
        .clk1       (clk1),
        .rst        (rst),
        .start      (start),
        .load_base  (load_base),
        .load_count (load_count),
        .bus        (bus),
        .core_hold  (core_hold),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .checksum   (checksum),
        .dbg_state  (dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk1 = ~clk1;

    int cyc = 0;
    always @(posedge clk1) cyc <= cyc + 1;

    int total = 0;
    int bad = 0;
    int we_count = 0;
    int we_cyc = -1;
    int last_acc_cyc = -1;
    logic [AW+31:0] exp_q[$];

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1, "watchdog");
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk1) begin
        if (bus.mem_we === 1'b1) begin
            logic [AW+31:0] e;
            we_count++;
            we_cyc = cyc;
            total++;
            if (exp_q.size() == 0) begin
                bad++;
                $display("FAIL unexpected_write: got addr=%0d data=%h, none expected",
                         bus.mem_addr, bus.mem_wdata);
            end else begin
                e = exp_q.pop_front();
                if ({bus.mem_addr, bus.mem_wdata} !== e) begin
                    bad++;
                    $display("FAIL mem_write: got addr=%0d data=%h, expected addr=%0d data=%h",
                             bus.mem_addr, bus.mem_wdata, e[AW+31:32], e[31:0]);
                end
            end
        end
    end

    // ---------------- reference model ----------------
    // A load of N words writes word i = bytes 4i..4i+3 (first byte most significant)
    // to base+i; the checksum is the 32-bit sum of those words.
    function automatic logic [31:0] model_load(input int base, input bytes_t bq);
        logic [31:0] sum = 32'd0;
        for (int i = 0; i < bq.size() / 4; i++) begin
            logic [31:0] w = {bq[4*i], bq[4*i+1], bq[4*i+2], bq[4*i+3]};
            logic [AW-1:0] a = AW'(base + i);
            exp_q.push_back({a, w});
            sum = sum + w;
        end
        return sum;
    endfunction

    function automatic bytes_t rand_bytes(input int n);
        bytes_t q;
        for (int i = 0; i < n; i++) q.push_back(8'($urandom_range(255, 0)));
        return q;
    endfunction

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk1);
            #1;
        end
    endtask

    task automatic do_start(input int base, input int count);
        load_base  = AW'(base);
        load_count = (AW+1)'(count);
        start      = 1'b1;
        tick(1);
        start      = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, output bit ok);
        int guard = 0;
        bus.in_valid = 1'b1;
        bus.in_byte  = b;
        while (bus.in_ready !== 1'b1 && guard < 50) begin
            tick(1);
            guard++;
        end
        if (bus.in_ready !== 1'b1) begin
            bus.in_valid = 1'b0;
            ok = 1'b0;
            return;
        end
        tick(1);
        last_acc_cyc = cyc;
        bus.in_valid = 1'b0;
        ok = 1'b1;
    endtask

    task automatic send_stream(input bytes_t bq, input int gmin, input int gmax, output bit ok);
        ok = 1'b1;
        foreach (bq[i]) begin
            bit b_ok;
            if (i != 0) tick(int'($urandom_range(gmax, gmin)));
            send_byte(bq[i], b_ok);
            if (!b_ok) begin
                ok = 1'b0;
                return;
            end
        end
    endtask

    task automatic wait_end(output bit ok);
        int g = 0;
        while (done !== 1'b1 && err !== 1'b1 && g < 64) begin
            tick(1);
            g++;
        end
        ok = (done === 1'b1) || (err === 1'b1);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        rst = 1'b1;
        start = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_byte = 8'h00;
        load_base = '0;
        load_count = '0;
        tick(3);
        total++;
        if ({core_hold, bus.in_ready, bus.mem_we, busy, done, err} !== 6'b100000) begin
            bad++;
            $display("FAIL reset_flags: got %b, expected 100000",
                     {core_hold, bus.in_ready, bus.mem_we, busy, done, err});
        end
        total++;
        if (checksum !== 32'd0) begin
            bad++;
            $display("FAIL reset_checksum: got %h, expected 0", checksum);
        end
        total++;
        if (dbg_state !== ST_IDLE) begin
            bad++;
            $display("FAIL reset_state: got %0d, expected %0d", dbg_state, ST_IDLE);
        end
        rst = 1'b0;
        tick(1);
    endtask

    task automatic test_directed();
        bytes_t bq = '{8'h28, 8'h01, 8'h00, 8'h0A, 8'h28, 8'h02, 8'h00, 8'h14};
        logic [31:0] sum = model_load(0, bq);
        bit ok_s, ok_e;
        do_start(0, 2);
        send_stream(bq, 0, 0, ok_s);
        wait_end(ok_e);
        total++;
        if (!(ok_s && ok_e)) begin
            bad++;
            $display("FAIL directed_finish: stream=%0b end=%0b, expected 1/1", ok_s, ok_e);
        end
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL directed_writes: %0d writes missing, expected 0", exp_q.size());
            exp_q.delete();
        end
        total++;
        if (checksum !== 32'h5003001E || checksum !== sum) begin
            bad++;
            $display("FAIL directed_checksum: got %h, expected 5003001e (model %h)", checksum, sum);
        end
        total++;
        if ({done, err, core_hold, busy} !== 4'b1000) begin
            bad++;
            $display("FAIL directed_flags: got done/err/hold/busy=%b, expected 1000",
                     {done, err, core_hold, busy});
        end
    endtask

    task automatic test_range_err();
        int we0 = we_count;
        do_start(1020, 5);
        total++;
        if ({err, done, busy, bus.in_ready, core_hold} !== 5'b10001) begin
            bad++;
            $display("FAIL range_err_flags: got err/done/busy/ready/hold=%b, expected 10001",
                     {err, done, busy, bus.in_ready, core_hold});
        end
        bus.in_valid = 1'b1;
        bus.in_byte = 8'hA5;
        tick(6);
        bus.in_valid = 1'b0;
        total++;
        if (we_count != we0 || bus.in_ready !== 1'b0 || err !== 1'b1) begin
            bad++;
            $display("FAIL range_err_idle: got writes=%0d ready=%b err=%b, expected 0/0/1",
                     we_count - we0, bus.in_ready, err);
        end
    endtask

    task automatic test_zero_count();
        bytes_t bq = rand_bytes(4);
        logic [31:0] sum;
        bit ok_s, ok_e;
        do_start(0, 0);
        total++;
        if (err !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL zero_count_err: got err=%b busy=%b, expected 1/0", err, busy);
        end
        sum = model_load(0, bq);
        do_start(0, 1);
        total++;
        if (err !== 1'b0 || busy !== 1'b1 || checksum !== 32'd0) begin
            bad++;
            $display("FAIL zero_count_restart: got err=%b busy=%b chk=%h, expected 0/1/0",
                     err, busy, checksum);
        end
        send_stream(bq, 0, 0, ok_s);
        wait_end(ok_e);
        total++;
        if (!(ok_s && ok_e) || done !== 1'b1 || exp_q.size() != 0 || checksum !== sum) begin
            bad++;
            $display("FAIL zero_count_load: got done=%b pending=%0d chk=%h, expected 1/0/%h",
                     done, exp_q.size(), checksum, sum);
            exp_q.delete();
        end
    endtask

    task automatic test_gapped();
        bytes_t bq = rand_bytes(4);
        logic [31:0] sum = model_load(7, bq);
        int we0 = we_count;
        bit ok_s, ok_e;
        do_start(7, 1);
        send_stream(bq, 1, 1, ok_s);
        wait_end(ok_e);
        total++;
        if (!(ok_s && ok_e) || exp_q.size() != 0 || checksum !== sum) begin
            bad++;
            $display("FAIL gapped_word: got pending=%0d chk=%h, expected 0/%h",
                     exp_q.size(), checksum, sum);
            exp_q.delete();
        end
        total++;
        if (we_count - we0 != 1) begin
            bad++;
            $display("FAIL gapped_we_count: got %0d strobes, expected 1", we_count - we0);
        end
        total++;
        if (we_cyc != last_acc_cyc) begin
            bad++;
            $display("FAIL gapped_we_timing: got strobe after edge %0d, expected after edge %0d",
                     we_cyc, last_acc_cyc);
        end
    endtask

    task automatic test_reset_mid();
        bytes_t part = rand_bytes(2);
        bytes_t bq = rand_bytes(8);
        logic [31:0] sum;
        int we0 = we_count;
        bit ok_s, ok_e;
        do_start(3, 2);
        send_stream(part, 0, 0, ok_s);
        bus.in_valid = 1'b1;
        bus.in_byte = 8'h5C;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        bus.in_valid = 1'b0;
        total++;
        if (dbg_state !== ST_IDLE || core_hold !== 1'b1 || busy !== 1'b0 || bus.in_ready !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid_state: got state=%0d hold=%b busy=%b ready=%b, expected %0d/1/0/0",
                     dbg_state, core_hold, busy, bus.in_ready, ST_IDLE);
        end
        tick(6);
        total++;
        if (we_count != we0) begin
            bad++;
            $display("FAIL reset_mid_nowrite: got %0d writes, expected 0", we_count - we0);
        end
        sum = model_load(3, bq);
        do_start(3, 2);
        send_stream(bq, 0, 1, ok_s);
        wait_end(ok_e);
        total++;
        if (!(ok_s && ok_e) || done !== 1'b1 || exp_q.size() != 0 || checksum !== sum) begin
            bad++;
            $display("FAIL reset_mid_reload: got done=%b pending=%0d chk=%h, expected 1/0/%h",
                     done, exp_q.size(), checksum, sum);
            exp_q.delete();
        end
    endtask

    task automatic test_start_ignored();
        bytes_t bq = rand_bytes(8);
        bytes_t head = '{bq[0], bq[1]};
        bytes_t tail = bq[2:7];
        logic [31:0] sum = model_load(5, bq);
        bit ok_h, ok_t, ok_e;
        do_start(5, 2);
        send_stream(head, 0, 0, ok_h);
        do_start(100, 1);
        send_stream(tail, 0, 0, ok_t);
        wait_end(ok_e);
        total++;
        if (!(ok_h && ok_t && ok_e) || done !== 1'b1 || exp_q.size() != 0 || checksum !== sum) begin
            bad++;
            $display("FAIL start_ignored: got done=%b pending=%0d chk=%h, expected 1/0/%h",
                     done, exp_q.size(), checksum, sum);
            exp_q.delete();
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 12; it++) begin
            int count = int'($urandom_range(4, 2));
            int base = int'($urandom_range(DEPTH - count, 0));
            bit ok_s, ok_e;
            if (it % 4 == 2) base = DEPTH - count;
            if (it % 4 == 3) begin
                int we0 = we_count;
                do_start(DEPTH - count + 1, count);
                tick(2);
                total++;
                if (err !== 1'b1 || we_count != we0 || bus.in_ready !== 1'b0) begin
                    bad++;
                    $display("FAIL random_range_err: got err=%b writes=%0d ready=%b, expected 1/0/0",
                             err, we_count - we0, bus.in_ready);
                end
            end else begin
                bytes_t bq = rand_bytes(4 * count);
                logic [31:0] sum = model_load(base, bq);
                do_start(base, count);
                send_stream(bq, 0, 2, ok_s);
                wait_end(ok_e);
                total++;
                if (!(ok_s && ok_e) || done !== 1'b1 || core_hold !== 1'b0 ||
                    exp_q.size() != 0 || checksum !== sum) begin
                    bad++;
                    $display("FAIL random_load: base=%0d count=%0d got done=%b hold=%b pending=%0d chk=%h, expected 1/0/0/%h",
                             base, count, done, core_hold, exp_q.size(), checksum, sum);
                    exp_q.delete();
                end
            end
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_range_err();
        test_zero_count();
        test_gapped();
        test_reset_mid();
        test_start_ignored();
        test_random();
        tick(3);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
